// File: rtl/rr_onehot_arbiter_if.sv
// Request/grant bundle between N requesters, the round-robin arbiter and the
// consumer that owns grant release.
//
// Handshake: the arbiter presents a grant by raising gnt_valid_o with a
// one-hot gnt_o and its index gnt_idx_o. The grant stays frozen until the
// consumer raises ack_i; a grant is released exactly at a rising clk edge
// where gnt_valid_o=1 and ack_i=1. ack_i while gnt_valid_o=0 has no meaning
// and is ignored. req_i bits are level requests and may change at any time.
interface rr_onehot_arbiter_if #(
    parameter int N    = 4,
    parameter int IDXW = $clog2(N)
);
    logic [N-1:0]    req_i;
    logic            ack_i;
    logic [N-1:0]    gnt_o;
    logic            gnt_valid_o;
    logic [IDXW-1:0] gnt_idx_o;
    logic [IDXW-1:0] ptr_o;
    logic            state_o;     // FSM state for observation: 0=IDLE, 1=GRANT

    // Requesters/consumer side: drives requests and acknowledges grants.
    modport master (
        output req_i, ack_i,
        input  gnt_o, gnt_valid_o, gnt_idx_o, ptr_o, state_o
    );

    // Arbiter side.
    modport slave (
        input  req_i, ack_i,
        output gnt_o, gnt_valid_o, gnt_idx_o, ptr_o, state_o
    );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered, sticky one-hot grant.
// The grant holds until acknowledged; on acknowledge the priority pointer
// moves past the served requester and the next grant is loaded in the same
// cycle, with the just-served requester excluded from that one search.
module rr_onehot_arbiter #(
    parameter  int N    = 4,
    localparam int IDXW = $clog2(N)
) (
    input logic                clk,
    input logic                reset,
    rr_onehot_arbiter_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            valid_q, valid_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IDXW-1:0] ptr_q, ptr_d;

    logic [IDXW-1:0] next_ptr;
    logic [IDXW:0]   pick;

    // First set bit of r, scanning start, start+1, ... modulo N.
    // Returns {found, index}.
    function automatic logic [IDXW:0] find_first(input logic [N-1:0] r,
                                                 input logic [IDXW-1:0] start);
        logic            found;
        logic [IDXW-1:0] idx;
        int              k;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(start) + i;
            if (k >= N) k = k - N;
            if (!found && r[k]) begin
                found = 1'b1;
                idx   = IDXW'(k);
            end
        end
        return {found, idx};
    endfunction

    // Next-state logic: fresh search in IDLE, release-and-reload on ack in GRANT.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        valid_d  = valid_q;
        idx_d    = idx_q;
        ptr_d    = ptr_q;
        next_ptr = (idx_q == IDXW'(N - 1)) ? '0 : idx_q + 1'b1;
        pick     = '0;

        case (state_q)
            IDLE: begin
                pick = find_first(bus.req_i, ptr_q);
                if (pick[IDXW]) begin
                    state_d = GRANT;
                    valid_d = 1'b1;
                    idx_d   = pick[IDXW-1:0];
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick[IDXW-1:0];
                end
            end
            GRANT: begin
                if (bus.ack_i) begin
                    ptr_d = next_ptr;
                    // The served requester sits out this one search only.
                    pick  = find_first(bus.req_i & ~gnt_q, next_ptr);
                    if (pick[IDXW]) begin
                        valid_d = 1'b1;
                        idx_d   = pick[IDXW-1:0];
                        gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick[IDXW-1:0];
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                idx_d   = '0;
                gnt_d   = '0;
            end
        endcase
    end

    // FSM state and registered outputs; reset clears everything, even mid-grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.gnt_o       = gnt_q;
    assign bus.gnt_valid_o = valid_q;
    assign bus.gnt_idx_o   = idx_q;
    assign bus.ptr_o       = ptr_q;
    assign bus.state_o     = (state_q == GRANT);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Directed bench for rr_onehot_arbiter (N=4). Each step drives inputs on the
// falling edge and queues the hand-computed outputs expected after the next
// rising edge; a monitor pops and compares after every rising edge.
module tb_rr_onehot_arbiter;
    localparam int N    = 4;
    localparam int IDXW = 2;
    localparam int W    = N + 1 + 2 * IDXW;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    rr_onehot_arbiter_if #(.N(N)) bus ();

    rr_onehot_arbiter #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Driver: apply one cycle of inputs and queue the expected outputs.
    task automatic step(input string nm, input logic r, input logic [N-1:0] rq,
                        input logic ak, input logic [N-1:0] eg,
                        input logic [IDXW-1:0] ei, input logic [IDXW-1:0] ep);
        @(negedge clk);
        reset      = r;
        bus.req_i  = rq;
        bus.ack_i  = ak;
        exp_q.push_back({eg, |eg, ei, ep});
        name_q.push_back(nm);
    endtask

    // Monitor: invariants every cycle, plus queued expectations.
    initial begin
        logic [W-1:0] e;
        string        nm;
        forever begin
            @(posedge clk);
            #2;
            check("inv_onehot0", int'($onehot0(bus.gnt_o)), 1);
            check("inv_valid", int'(bus.gnt_valid_o), int'(|bus.gnt_o));
            if (bus.gnt_valid_o)
                check("inv_idx_match", int'(bus.gnt_o), int'(4'b0001 << bus.gnt_idx_o));
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, "_gnt"},   int'(bus.gnt_o),       int'(e[W-1 -: N]));
                check({nm, "_valid"}, int'(bus.gnt_valid_o), int'(e[2*IDXW]));
                check({nm, "_idx"},   int'(bus.gnt_idx_o),   int'(e[2*IDXW-1 -: IDXW]));
                check({nm, "_ptr"},   int'(bus.ptr_o),       int'(e[IDXW-1:0]));
            end
        end
    end

    // Stimulus: (name, reset, req, ack, exp gnt, exp idx, exp ptr)
    initial begin
        bus.req_i = '0;
        bus.ack_i = 1'b0;

        step("reset",   1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0);
        // Idle with stray acks
        step("idle0",   1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0);
        step("idle1",   1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0);
        step("idle2",   1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0);
        step("idle3",   1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 2'd0);
        step("idle4",   1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0);
        // Rotation with all requesting and ack every cycle
        step("rot0",    1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 2'd0);
        step("rot1",    1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 2'd1);
        step("rot2",    1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 2'd2);
        step("rot3",    1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 2'd3);
        step("rot4",    1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 2'd0);
        step("rot_end", 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd1);
        // Single sticky request; req drops while granted
        step("single",  1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 2'd1);
        step("hold0",   1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 2'd1);
        step("hold1",   1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 2'd1);
        step("hold2",   1'b0, 4'b0000, 1'b0, 4'b0100, 2'd2, 2'd1);
        step("release", 1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd3);
        // Wrap from ptr=3
        step("wrap",    1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 2'd3);
        step("wrap_ack",1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd1);
        // Sole repeat requester: idle gap from the exclusion rule
        step("sole0",   1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 2'd1);
        step("sole1",   1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0, 2'd2);
        step("sole2",   1'b0, 4'b0010, 1'b1, 4'b0010, 2'd1, 2'd2);
        step("sole3",   1'b0, 4'b0010, 1'b1, 4'b0000, 2'd0, 2'd2);
        step("sole4",   1'b0, 4'b0010, 1'b0, 4'b0010, 2'd1, 2'd2);
        // Back-to-back to requester 3, then reset mid-grant
        step("to3",     1'b0, 4'b1000, 1'b1, 4'b1000, 2'd3, 2'd2);
        step("midrst",  1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 2'd0);
        step("postrst", 1'b0, 4'b1001, 1'b0, 4'b0001, 2'd0, 2'd0);
        step("post_b2b",1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 2'd1);
        step("post_end",1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 2'd0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #5;
        check("queue_drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
